// File: rtl/fwd_pkg.sv
// Shared widths and pipeline-entry payloads for the EX-stage forwarding unit.
package fwd_pkg;

    localparam int unsigned opSize      = 24;
    localparam int unsigned regAddrBits = 4;

    localparam logic [regAddrBits-1:0] ZERO_REG = '0;

    // In-flight writer sitting in MEM; a load's data is only known once it leaves MEM.
    typedef struct packed {
        logic                   valid;
        logic [regAddrBits-1:0] rd;
        logic [opSize-1:0]      data;
        logic                   is_load;
    } fwd_entry_t;

    // Writer in WB: data already resolved, so no load flag is kept.
    typedef struct packed {
        logic                   valid;
        logic [regAddrBits-1:0] rd;
        logic [opSize-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding decision against the MEM and WB writer entries.
module fwd_select
    import fwd_pkg::*;
(
    input  logic [regAddrBits-1:0] rs,
    input  logic                   use_src,
    input  fwd_entry_t             mem,
    input  wb_entry_t              wb,
    output logic                   fwd,
    output logic [opSize-1:0]      value,
    output logic                   hazard
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = use_src && mem.valid && (mem.rd == rs) && (rs != ZERO_REG);
    assign wb_hit  = use_src && wb.valid  && (wb.rd  == rs) && (rs != ZERO_REG);

    // Youngest writer wins; a load still in MEM cannot supply data yet.
    always_comb begin
        fwd    = 1'b0;
        value  = '0;
        hazard = 1'b0;
        if (mem_hit) begin
            if (mem.is_load) begin
                hazard = 1'b1;
            end else begin
                fwd   = 1'b1;
                value = mem.data;
            end
        end else if (wb_hit) begin
            fwd   = 1'b1;
            value = wb.data;
        end
    end

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage forwarding unit: tracks MEM/WB writers, drives operand selects, load-use stall and RF write port.
module forwarding_unit
    import fwd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [regAddrBits-1:0] ex_rs1,
    input  logic [regAddrBits-1:0] ex_rs2,
    input  logic [regAddrBits-1:0] ex_rs3,
    input  logic                   ex_use1,
    input  logic                   ex_use2,
    input  logic                   ex_use3,
    input  logic                   ex_we,
    input  logic [regAddrBits-1:0] ex_rd,
    input  logic                   ex_is_load,
    input  logic [opSize-1:0]      ex_result,
    input  logic [opSize-1:0]      mem_rdata,
    input  logic                   hold,
    input  logic                   flush,
    output logic                   Fa,
    output logic                   Fb,
    output logic                   Fc,
    output logic [opSize-1:0]      Forward1,
    output logic [opSize-1:0]      Forward2,
    output logic [opSize-1:0]      Forward3,
    output logic                   stall,
    output logic                   wb_we,
    output logic [regAddrBits-1:0] wb_rd,
    output logic [opSize-1:0]      wb_data
);

    fwd_entry_t mem_q;
    wb_entry_t  wb_q;
    logic       hazard1;
    logic       hazard2;
    logic       hazard3;

    fwd_select u_sel1 (
        .rs      (ex_rs1),
        .use_src (ex_use1),
        .mem     (mem_q),
        .wb      (wb_q),
        .fwd     (Fa),
        .value   (Forward1),
        .hazard  (hazard1)
    );

    fwd_select u_sel2 (
        .rs      (ex_rs2),
        .use_src (ex_use2),
        .mem     (mem_q),
        .wb      (wb_q),
        .fwd     (Fb),
        .value   (Forward2),
        .hazard  (hazard2)
    );

    fwd_select u_sel3 (
        .rs      (ex_rs3),
        .use_src (ex_use3),
        .mem     (mem_q),
        .wb      (wb_q),
        .fwd     (Fc),
        .value   (Forward3),
        .hazard  (hazard3)
    );

    assign stall = hazard1 | hazard2 | hazard3;

    // Advance EX->MEM->WB; a stalled or flushed EX instruction becomes a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!hold) begin
            if (stall || flush) begin
                mem_q <= '0;
            end else begin
                mem_q.valid   <= ex_we && (ex_rd != ZERO_REG);
                mem_q.rd      <= ex_rd;
                mem_q.data    <= ex_result;
                mem_q.is_load <= ex_is_load;
            end
            wb_q.valid <= mem_q.valid;
            wb_q.rd    <= mem_q.rd;
            wb_q.data  <= mem_q.is_load ? mem_rdata : mem_q.data;
        end
    end

    assign wb_we   = wb_q.valid;
    assign wb_rd   = wb_q.rd;
    assign wb_data = wb_q.data;

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed plus randomized checks of forwarding_unit against an in-flight instruction history model.
module tb_forwarding_unit;
    import fwd_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [regAddrBits-1:0] ex_rs1, ex_rs2, ex_rs3;
    logic                   ex_use1, ex_use2, ex_use3;
    logic                   ex_we;
    logic [regAddrBits-1:0] ex_rd;
    logic                   ex_is_load;
    logic [opSize-1:0]      ex_result;
    logic [opSize-1:0]      mem_rdata;
    logic                   hold;
    logic                   flush;
    logic                   Fa, Fb, Fc;
    logic [opSize-1:0]      Forward1, Forward2, Forward3;
    logic                   stall;
    logic                   wb_we;
    logic [regAddrBits-1:0] wb_rd;
    logic [opSize-1:0]      wb_data;

    always #5 clk = ~clk;

    forwarding_unit dut (
        .clk        (clk),
        .rst        (rst),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rs3     (ex_rs3),
        .ex_use1    (ex_use1),
        .ex_use2    (ex_use2),
        .ex_use3    (ex_use3),
        .ex_we      (ex_we),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .ex_result  (ex_result),
        .mem_rdata  (mem_rdata),
        .hold       (hold),
        .flush      (flush),
        .Fa         (Fa),
        .Fb         (Fb),
        .Fc         (Fc),
        .Forward1   (Forward1),
        .Forward2   (Forward2),
        .Forward3   (Forward3),
        .stall      (stall),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    // History of instructions that left EX: index 0 = one cycle ago, 1 = two cycles ago.
    typedef struct {
        bit                     writes;
        logic [regAddrBits-1:0] rd;
        logic [opSize-1:0]      val;
        bit                     load;
    } ins_t;

    ins_t flight [2];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [opSize-1:0] obs, input logic [opSize-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void expect_op(input logic [regAddrBits-1:0] rs, input logic u,
                                      output logic f, output logic [opSize-1:0] v, output logic h);
        f = 1'b0;
        v = '0;
        h = 1'b0;
        if (u && rs != 0) begin
            for (int age = 0; age < 2; age++) begin
                if (flight[age].writes && flight[age].rd == rs) begin
                    if (age == 0 && flight[age].load) h = 1'b1;
                    else begin
                        f = 1'b1;
                        v = flight[age].val;
                    end
                    break;
                end
            end
        end
    endfunction

    function automatic logic model_stall();
        logic f;
        logic [opSize-1:0] v;
        logic h1, h2, h3;
        expect_op(ex_rs1, ex_use1, f, v, h1);
        expect_op(ex_rs2, ex_use2, f, v, h2);
        expect_op(ex_rs3, ex_use3, f, v, h3);
        return h1 | h2 | h3;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            flight[i].writes = 0;
            flight[i].rd     = '0;
            flight[i].val    = '0;
            flight[i].load   = 0;
        end
    endtask

    // Compare every output against the model, sampled on the falling edge.
    task automatic compare_all();
        logic f;
        logic [opSize-1:0] v;
        logic h1, h2, h3;
        @(negedge clk);
        expect_op(ex_rs1, ex_use1, f, v, h1);
        check("Fa", 24'(Fa), 24'(f));
        check("Forward1", Forward1, v);
        expect_op(ex_rs2, ex_use2, f, v, h2);
        check("Fb", 24'(Fb), 24'(f));
        check("Forward2", Forward2, v);
        expect_op(ex_rs3, ex_use3, f, v, h3);
        check("Fc", 24'(Fc), 24'(f));
        check("Forward3", Forward3, v);
        check("stall", 24'(stall), 24'(h1 | h2 | h3));
        check("wb_we", 24'(wb_we), 24'(flight[1].writes));
        if (flight[1].writes) begin
            check("wb_rd", 24'(wb_rd), 24'(flight[1].rd));
            check("wb_data", wb_data, flight[1].val);
        end
    endtask

    task automatic advance();
        logic st;
        @(posedge clk);
        st = model_stall();
        if (!rst) clear_model();
        else if (!hold) begin
            flight[1].writes = flight[0].writes;
            flight[1].rd     = flight[0].rd;
            flight[1].val    = flight[0].load ? mem_rdata : flight[0].val;
            flight[1].load   = 0;
            if (st || flush) begin
                flight[0].writes = 0;
                flight[0].load   = 0;
            end else begin
                flight[0].writes = ex_we && ex_rd != 0;
                flight[0].rd     = ex_rd;
                flight[0].val    = ex_result;
                flight[0].load   = ex_is_load;
            end
        end
        #1;
    endtask

    task automatic step();
        compare_all();
        advance();
    endtask

    task automatic idle();
        {ex_rs1, ex_rs2, ex_rs3} = '0;
        {ex_use1, ex_use2, ex_use3} = '0;
        ex_we = 0; ex_rd = '0; ex_is_load = 0; ex_result = '0;
        hold = 0; flush = 0;
    endtask

    task automatic produce(input logic [regAddrBits-1:0] rd, input logic [opSize-1:0] res, input logic ld);
        ex_we = 1; ex_rd = rd; ex_result = res; ex_is_load = ld;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_Fabc"}, 24'({Fa, Fb, Fc}), 24'(0));
        check({tag, "_fwd"}, Forward1 | Forward2 | Forward3, 24'(0));
        check({tag, "_stall"}, 24'(stall), 24'(0));
        check({tag, "_wb_we"}, 24'(wb_we), 24'(0));
        check({tag, "_wb_rd"}, 24'(wb_rd), 24'(0));
        check({tag, "_wb_data"}, wb_data, 24'(0));
    endtask

    initial begin
        idle();
        mem_rdata = '0;
        rst = 0;
        clear_model();
        advance();
        advance();
        rst = 1;
        check_all_zero("reset");

        // ALU chain through MEM then WB
        produce(4'd3, 24'h00000A, 0); step();
        idle(); ex_rs1 = 3; ex_use1 = 1;
        compare_all();
        check("alu_fa", 24'(Fa), 24'(1));
        check("alu_fwd1", Forward1, 24'h00000A);
        advance();
        idle(); ex_rs2 = 3; ex_use2 = 1;
        compare_all();
        check("alu_fb", 24'(Fb), 24'(1));
        check("alu_fwd2", Forward2, 24'h00000A);
        check("alu_wb_rd", 24'(wb_rd), 24'(3));
        advance();

        // Double write: MEM beats WB
        idle(); produce(4'd5, 24'h111111, 0); step();
        idle(); produce(4'd5, 24'h222222, 0); step();
        idle(); ex_rs3 = 5; ex_use3 = 1;
        compare_all();
        check("dbl_fc", 24'(Fc), 24'(1));
        check("dbl_fwd3", Forward3, 24'h222222);
        advance();

        // Load-use: one stall cycle, then data from memory
        idle(); produce(4'd2, 24'h555555, 1); step();
        idle(); ex_rs1 = 2; ex_use1 = 1; mem_rdata = 24'hABCDEF;
        compare_all();
        check("lu_stall", 24'(stall), 24'(1));
        check("lu_fa", 24'(Fa), 24'(0));
        advance();
        mem_rdata = 24'h000000;
        compare_all();
        check("lu2_stall", 24'(stall), 24'(0));
        check("lu2_fwd1", Forward1, 24'hABCDEF);
        advance();

        // r0 never forwarded; unused source never forwards or stalls
        idle(); produce(4'd0, 24'hFFFFFF, 0); step();
        idle(); ex_rs1 = 0; ex_use1 = 1; produce(4'd6, 24'h666666, 1);
        compare_all();
        check("r0_fa", 24'(Fa), 24'(0));
        advance();
        idle(); ex_rs2 = 6; ex_use2 = 0;
        compare_all();
        check("unused_stall", 24'(stall), 24'(0));
        check("r0_wb_we", 24'(wb_we), 24'(0));
        advance();

        // Flushed producer never forwards or writes back
        idle(); produce(4'd4, 24'h444444, 0); flush = 1; step();
        idle(); ex_rs1 = 4; ex_use1 = 1; step();
        step();
        check("flush_wb_we", 24'(wb_we), 24'(0));

        // Hold freezes state for three cycles
        idle(); produce(4'd7, 24'h070707, 0); step();
        idle(); produce(4'd8, 24'h080808, 0); ex_rs1 = 7; ex_use1 = 1; step();
        hold = 1; produce(4'd9, 24'h090909, 0);
        for (int i = 0; i < 3; i++) begin
            compare_all();
            check("hold_fwd1", Forward1, 24'h070707);
            check("hold_wb_rd", 24'(wb_rd), 24'(7));
            advance();
        end
        hold = 0; step();
        idle(); ex_rs2 = 8; ex_use2 = 1; step();

        // Reset with both entries valid
        idle(); produce(4'd9, 24'h999999, 0); step();
        produce(4'd10, 24'hAAAAAA, 0); step();
        idle(); rst = 0; advance();
        rst = 1;
        check_all_zero("midreset");
        step();

        // Randomized traffic over a small register set to provoke frequent matches
        for (int n = 0; n < 600; n++) begin
            ex_rs1     = 4'($urandom_range(7));
            ex_rs2     = 4'($urandom_range(7));
            ex_rs3     = 4'($urandom_range(7));
            ex_use1    = 1'($urandom);
            ex_use2    = 1'($urandom);
            ex_use3    = 1'($urandom);
            ex_we      = 1'($urandom);
            ex_rd      = 4'($urandom_range(7));
            ex_is_load = ($urandom_range(3) == 0);
            ex_result  = 24'($urandom);
            mem_rdata  = 24'($urandom);
            flush      = ($urandom_range(9) == 0);
            hold       = ($urandom_range(7) == 0);
            rst        = ($urandom_range(49) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
